// File: rtl/sprite_fetch_sequencer_pkg.sv
// Shared constants for the sprite pattern fetch: FSM states, step numbering,
// sprite state word layout and word/bit helpers.
package ppu_spr_pkg;

    typedef logic [0:0] spr_state_t;

    localparam spr_state_t ST_IDLE  = 1'b0;
    localparam spr_state_t ST_FETCH = 1'b1;

    localparam logic [2:0] STEP_ADDR = 3'd0;
    localparam logic [2:0] STEP_Y    = 3'd1;
    localparam logic [2:0] STEP_TILE = 3'd2;
    localparam logic [2:0] STEP_ATTR = 3'd3;
    localparam logic [2:0] STEP_X    = 3'd4;
    localparam logic [2:0] STEP_LO   = 3'd5;
    localparam logic [2:0] STEP_HI   = 3'd6;
    localparam logic [2:0] STEP_LOAD = 3'd7;

    localparam int SPR_W      = 27;
    localparam int OFS_PAT_LO = 0;
    localparam int OFS_PAT_HI = 8;
    localparam int OFS_PAL    = 16;
    localparam int OFS_PRI    = 18;
    localparam int OFS_X      = 19;

    localparam logic [3:0] LOAD_ALL = 4'b1111;

    function automatic logic [7:0] bit_rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    function automatic logic [SPR_W-1:0] pack_word(input logic [7:0] x,
                                                   input logic       pri,
                                                   input logic [1:0] pal,
                                                   input logic [7:0] hi,
                                                   input logic [7:0] lo);
        logic [SPR_W-1:0] w;
        w = '0;
        w[OFS_X +: 8]      = x;
        w[OFS_PRI]         = pri;
        w[OFS_PAL +: 2]    = pal;
        w[OFS_PAT_HI +: 8] = hi;
        w[OFS_PAT_LO +: 8] = lo;
        return w;
    endfunction

endpackage

// File: rtl/sprite_fetch_sequencer_if.sv
// Timing inputs, secondary-OAM / VRAM read buses and sprite-set load port
// of the sprite fetch sequencer.
interface sprite_fetch_sequencer_if;

    logic        ce;
    logic        rendering;
    logic [8:0]  cycle;
    logic [8:0]  scanline;
    logic        obj_size;
    logic        obj_patt;
    logic [3:0]  spr_count;
    logic [4:0]  soam_addr;
    logic [7:0]  soam_data;
    logic [13:0] vram_addr;
    logic        vram_rd;
    logic [7:0]  vram_data;
    logic [3:0]  spr_load;
    logic [26:0] spr_load_in;
    logic        spr_enable;
    logic        fetch_active;

    modport master (
        input  ce, rendering, cycle, scanline, obj_size, obj_patt, spr_count,
        input  soam_data, vram_data,
        output soam_addr, vram_addr, vram_rd, spr_load, spr_load_in,
        output spr_enable, fetch_active
    );

    modport slave (
        output ce, rendering, cycle, scanline, obj_size, obj_patt, spr_count,
        output soam_data, vram_data,
        input  soam_addr, vram_addr, vram_rd, spr_load, spr_load_in,
        input  spr_enable, fetch_active
    );

endinterface

// File: rtl/sprite_fetch_sequencer_addr.sv
// Pattern-table address for one sprite plane: sprite row within the tile
// (with vertical flip) folded into the 8x8 or 8x16 address layout.
module spr_pattern_addr (
    input  logic [3:0]  line_lo,
    input  logic [3:0]  y_lo,
    input  logic [7:0]  tile,
    input  logic        vflip,
    input  logic        obj_size,
    input  logic        obj_patt,
    input  logic        plane,
    output logic [13:0] addr
);

    logic [3:0] row;

    // Only the low nibble of (scanline - Y) can reach the address, so the
    // subtraction is done at 4 bits; the borrow out of bit 3 is irrelevant.
    always_comb begin
        row = line_lo - y_lo;
        if (vflip) row = row ^ (obj_size ? 4'hF : 4'h7);
        if (obj_size) addr = {1'b0, tile[0], tile[7:1], row[3], plane, row[2:0]};
        else          addr = {1'b0, obj_patt, tile, plane, row[2:0]};
    end

endmodule

// File: rtl/sprite_fetch_sequencer.sv
// Sprite pattern fetch for dots 257-320: eight slots of secondary-OAM reads,
// two pattern reads each, then one load of the assembled word into the sprite set.
module sprite_fetch_sequencer
    import ppu_spr_pkg::*;
(
    input  logic                            clk,
    input  logic                            reset,
    sprite_fetch_sequencer_if.master        bus
);

    spr_state_t  state;
    logic [2:0]  slot;
    logic [2:0]  step;
    logic [3:0]  eff_count;

    logic [3:0]  y_r;
    logic [7:0]  tile_r;
    logic [7:0]  x_r;
    logic [7:0]  lo_r;
    logic [7:0]  hi_r;
    logic        vflip_r;
    logic        hflip_r;
    logic        pri_r;
    logic [1:0]  pal_r;

    logic        trigger;
    logic        slot_empty;
    logic        plane;
    logic [13:0] pat_addr;
    logic [7:0]  lo_out;
    logic [7:0]  hi_out;

    assign trigger    = bus.rendering && (bus.cycle == 9'd257) &&
                        ((bus.scanline < 9'd240) || (bus.scanline == 9'd261));
    assign slot_empty = ({1'b0, slot} >= eff_count);
    assign plane      = (step == STEP_LO);
    assign lo_out     = hflip_r ? bit_rev8(lo_r) : lo_r;
    assign hi_out     = hflip_r ? bit_rev8(hi_r) : hi_r;

    assign bus.fetch_active = (state == ST_FETCH);

    spr_pattern_addr u_pattern_addr (
        .line_lo  (bus.scanline[3:0]),
        .y_lo     (y_r),
        .tile     (tile_r),
        .vflip    (vflip_r),
        .obj_size (bus.obj_size),
        .obj_patt (bus.obj_patt),
        .plane    (plane),
        .addr     (pat_addr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            slot            <= 3'd0;
            step            <= 3'd0;
            eff_count       <= 4'd0;
            bus.soam_addr   <= 5'd0;
            bus.vram_addr   <= 14'd0;
            bus.vram_rd     <= 1'b0;
            bus.spr_load    <= 4'd0;
            bus.spr_load_in <= '0;
            bus.spr_enable  <= 1'b0;
        end else if (bus.ce) begin
            bus.spr_enable <= bus.rendering && (bus.scanline < 9'd240) &&
                              (bus.cycle >= 9'd1) && (bus.cycle <= 9'd256);
            bus.spr_load   <= 4'd0;
            bus.vram_rd    <= 1'b0;
            if (state == ST_IDLE) begin
                // The trigger dot is itself step 0 of slot 0.
                if (trigger) begin
                    state         <= ST_FETCH;
                    slot          <= 3'd0;
                    step          <= STEP_Y;
                    eff_count     <= (bus.scanline == 9'd261) ? 4'd0 : bus.spr_count;
                    bus.soam_addr <= 5'd0;
                end
            end else if (!bus.rendering) begin
                state <= ST_IDLE;
            end else begin
                step <= step + 3'd1;
                case (step)
                    STEP_ADDR, STEP_Y, STEP_TILE, STEP_ATTR:
                        bus.soam_addr <= {slot, step[1:0]};
                    STEP_X, STEP_LO: begin
                        bus.vram_addr <= pat_addr;
                        bus.vram_rd   <= 1'b1;
                    end
                    STEP_LOAD: begin
                        bus.spr_load    <= LOAD_ALL;
                        bus.spr_load_in <= pack_word(x_r, pri_r, pal_r, hi_out, lo_out);
                        slot            <= slot + 3'd1;
                        if (slot == 3'd7) state <= ST_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Per-slot capture registers; empty slots are forced to a transparent sprite.
    always_ff @(posedge clk) begin
        if (bus.ce && (state == ST_FETCH)) begin
            case (step)
                STEP_Y:    y_r    <= bus.soam_data[3:0];
                STEP_TILE: tile_r <= slot_empty ? 8'hFF : bus.soam_data;
                STEP_ATTR: begin
                    vflip_r <= !slot_empty && bus.soam_data[7];
                    hflip_r <= !slot_empty && bus.soam_data[6];
                    pri_r   <= !slot_empty && bus.soam_data[5];
                    pal_r   <= slot_empty ? 2'd0 : bus.soam_data[1:0];
                end
                STEP_X:    x_r  <= slot_empty ? 8'hFF : bus.soam_data;
                STEP_LO:   lo_r <= slot_empty ? 8'h00 : bus.vram_data;
                STEP_HI:   hi_r <= slot_empty ? 8'h00 : bus.vram_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_fetch_sequencer.sv
// Bench for sprite_fetch_sequencer: whole scanlines driven dot by dot with
// random ce gaps, checked against an arithmetic model of the fetch schedule.
module tb_sprite_fetch_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [7:0]  vram [0:16383];
    logic [7:0]  soam [0:31];
    logic [26:0] obs_word [0:7];
    logic [13:0] obs_lo   [0:7];
    logic [13:0] obs_hi   [0:7];
    int          loads;
    logic [3:0]  prev_ld = 4'd0;
    logic        prev_rd = 1'b0;

    sprite_fetch_sequencer_if bus ();

    sprite_fetch_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.soam_data = soam[bus.soam_addr];
        bus.vram_data = vram[bus.vram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic int pat_addr_m(int sl, int y, int tile, int attr, bit big, bit patt, int plane);
        int row;
        row = (sl - y) & 255;
        if ((attr & 128) != 0) row = row ^ (big ? 15 : 7);
        if (!big) return int'(patt) * 4096 + tile * 16 + plane * 8 + (row & 7);
        return (tile & 1) * 4096 + (tile >> 1) * 32 + ((row >> 3) & 1) * 16 + plane * 8 + (row & 7);
    endfunction

    function automatic int rev_m(int b);
        int r = 0;
        for (int i = 0; i < 8; i++) r = r * 2 + ((b >> i) & 1);
        return r;
    endfunction

    function automatic int exp_addr(int s, int sl, int eff, bit big, bit patt, int plane);
        int t, a;
        t = (s < eff) ? int'(soam[4*s+1]) : 255;
        a = (s < eff) ? int'(soam[4*s+2]) : 0;
        return pat_addr_m(sl, int'(soam[4*s]), t, a, big, patt, plane);
    endfunction

    function automatic int exp_word(int s, int sl, int eff, bit big, bit patt);
        int a, x, lo, hi;
        if (s >= eff) return 32'h7F80000;
        a  = int'(soam[4*s+2]);
        x  = int'(soam[4*s+3]);
        lo = int'(vram[exp_addr(s, sl, eff, big, patt, 0)]);
        hi = int'(vram[exp_addr(s, sl, eff, big, patt, 1)]);
        if ((a & 64) != 0) begin
            lo = rev_m(lo);
            hi = rev_m(hi);
        end
        return x * 524288 + ((a >> 5) & 1) * 262144 + (a & 3) * 65536 + hi * 256 + lo;
    endfunction

    task automatic fill_soam();
        for (int i = 0; i < 32; i++) soam[i] = 8'($urandom);
    endtask

    task automatic set_slot(input int s, input int y, input int t, input int a, input int x);
        soam[4*s]   = 8'(y);
        soam[4*s+1] = 8'(t);
        soam[4*s+2] = 8'(a);
        soam[4*s+3] = 8'(x);
    endtask

    task automatic run_line(input int sl, input int cnt, input bit big, input bit patt,
                            input int drop_at, input int rst_at);
        bit   live;
        bit   r;
        int   eff, k, s;
        bit   in_win;
        logic [3:0] exp_ld;
        logic exp_rd;
        live  = 1'b0;
        eff   = 0;
        loads = 0;
        bus.obj_size  = big;
        bus.obj_patt  = patt;
        bus.spr_count = 4'(cnt);
        for (int c = 0; c <= 340; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                bus.ce = 1'b0;
                reset  = 1'b0;
                @(posedge clk); #1;
                chk("hold_spr_load", 32'(bus.spr_load), 32'(prev_ld));
                chk("hold_vram_rd", 32'(bus.vram_rd), 32'(prev_rd));
            end
            r = !(drop_at >= 0 && c >= drop_at);
            bus.ce        = 1'b1;
            bus.cycle     = 9'(c);
            bus.scanline  = 9'(sl);
            bus.rendering = r;
            reset         = (c == rst_at);
            @(posedge clk); #1;
            if (c == rst_at) begin
                chk("rst_soam_addr", 32'(bus.soam_addr), 32'd0);
                chk("rst_vram_addr", 32'(bus.vram_addr), 32'd0);
                chk("rst_vram_rd", 32'(bus.vram_rd), 32'd0);
                chk("rst_spr_load", 32'(bus.spr_load), 32'd0);
                chk("rst_spr_load_in", 32'(bus.spr_load_in), 32'd0);
                chk("rst_spr_enable", 32'(bus.spr_enable), 32'd0);
                chk("rst_fetch_active", 32'(bus.fetch_active), 32'd0);
                live    = 1'b0;
                prev_ld = 4'd0;
                prev_rd = 1'b0;
                reset   = 1'b0;
                continue;
            end
            if (c == 257 && r && (sl < 240 || sl == 261)) begin
                live = 1'b1;
                eff  = (sl == 261) ? 0 : cnt;
            end
            if (!r) live = 1'b0;
            in_win = live && c >= 257 && c <= 320;
            k = (c - 257) % 8;
            s = (c - 257) / 8;
            exp_rd = in_win && (k == 4 || k == 5);
            exp_ld = (in_win && k == 7) ? 4'hF : 4'h0;
            chk("spr_enable", 32'(bus.spr_enable), 32'(r && sl < 240 && c >= 1 && c <= 256));
            chk("fetch_active", 32'(bus.fetch_active), 32'(in_win && c < 320));
            chk("vram_rd", 32'(bus.vram_rd), 32'(exp_rd));
            chk("spr_load", 32'(bus.spr_load), 32'(exp_ld));
            if (in_win && k <= 3)
                chk("soam_addr", 32'(bus.soam_addr), 32'(s * 4 + k));
            if (in_win && (k == 4 || k == 5)) begin
                chk("vram_addr", 32'(bus.vram_addr), 32'(exp_addr(s, sl, eff, big, patt, k - 4)));
                if (k == 4) obs_lo[s] = bus.vram_addr;
                else        obs_hi[s] = bus.vram_addr;
            end
            if (in_win && k == 7) begin
                chk("spr_load_in", 32'(bus.spr_load_in), 32'(exp_word(s, sl, eff, big, patt)));
                obs_word[s] = bus.spr_load_in;
            end
            if (bus.spr_load == 4'hF) loads = loads + 1;
            if (c >= 320) live = 1'b0;
            prev_ld = exp_ld;
            prev_rd = exp_rd;
        end
        bus.ce = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) vram[i] = 8'($urandom);
        fill_soam();
        for (int i = 0; i < 8; i++) begin
            obs_word[i] = '0;
            obs_lo[i]   = '0;
            obs_hi[i]   = '0;
        end
        bus.ce = 1'b0; bus.rendering = 1'b0; bus.cycle = 9'd0; bus.scanline = 9'd0;
        bus.obj_size = 1'b0; bus.obj_patt = 1'b0; bus.spr_count = 4'd0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("init_soam_addr", 32'(bus.soam_addr), 32'd0);
        chk("init_vram_addr", 32'(bus.vram_addr), 32'd0);
        chk("init_vram_rd", 32'(bus.vram_rd), 32'd0);
        chk("init_spr_load", 32'(bus.spr_load), 32'd0);
        chk("init_spr_load_in", 32'(bus.spr_load_in), 32'd0);
        chk("init_spr_enable", 32'(bus.spr_enable), 32'd0);
        chk("init_fetch_active", 32'(bus.fetch_active), 32'd0);
        reset = 1'b0;

        // Single 8x8 sprite, no flips
        set_slot(0, 5, 'h42, 'h01, 'h30);
        vram[14'h1425] = 8'hA5;
        vram[14'h142D] = 8'h0F;
        run_line(10, 1, 1'b0, 1'b1, -1, -1);
        chk("t1_lo_addr", 32'(obs_lo[0]), 32'h1425);
        chk("t1_hi_addr", 32'(obs_hi[0]), 32'h142D);
        chk("t1_word", 32'(obs_word[0]), 32'({8'h30, 1'b0, 2'b01, 8'h0F, 8'hA5}));
        chk("t1_loads", 32'(loads), 32'd8);

        // Both flips: row 5 becomes 2, pattern bytes reversed
        set_slot(0, 5, 'h42, 'hC0, 'h30);
        vram[14'h1422] = 8'hA5;
        vram[14'h142A] = 8'h0F;
        run_line(10, 1, 1'b0, 1'b1, -1, -1);
        chk("t2_lo_addr", 32'(obs_lo[0]), 32'h1422);
        chk("t2_word", 32'(obs_word[0]), 32'({8'h30, 1'b0, 2'b00, 8'hF0, 8'hA5}));

        // 8x16, tile 0x43 on row 9: table 1, tile[7:1]=0x21, row[3]=1, row[2:0]=1
        set_slot(0, 11, 'h43, 'h00, 'h55);
        run_line(20, 1, 1'b1, 1'b0, -1, -1);
        chk("t3_lo_addr", 32'(obs_lo[0]), 32'h1431);

        // Three valid sprites, five empty slots
        fill_soam();
        run_line(100, 3, 1'b0, 1'b0, -1, -1);
        chk("t4_loads", 32'(loads), 32'd8);
        for (int i = 3; i < 8; i++) chk("t4_empty_word", 32'(obs_word[i]), 32'h7F80000);

        // Rendering drops mid-fetch
        fill_soam();
        run_line(50, 8, 1'b0, 1'b1, 290, -1);
        chk("t5_loads", 32'(loads), 32'd4);
        run_line(51, 8, 1'b0, 1'b1, -1, -1);
        chk("t5_recover_loads", 32'(loads), 32'd8);

        // Reset mid-fetch
        fill_soam();
        run_line(60, 5, 1'b1, 1'b0, -1, 270);
        chk("t6_loads", 32'(loads), 32'd1);

        // Pre-render line: every slot empty regardless of spr_count
        fill_soam();
        run_line(261, 5, 1'b0, 1'b1, -1, -1);
        chk("t7_loads", 32'(loads), 32'd8);
        chk("t7_word0", 32'(obs_word[0]), 32'h7F80000);

        // Line boundaries and rendering off
        run_line(239, 8, 1'b1, 1'b1, -1, -1);
        chk("t8_loads_239", 32'(loads), 32'd8);
        run_line(240, 8, 1'b0, 1'b0, -1, -1);
        chk("t8_loads_240", 32'(loads), 32'd0);
        run_line(30, 4, 1'b0, 1'b0, 0, -1);
        chk("t8_loads_off", 32'(loads), 32'd0);

        for (int n = 0; n < 4; n++) begin
            fill_soam();
            run_line(int'($urandom_range(0, 239)), int'($urandom_range(0, 8)),
                     1'($urandom), 1'($urandom), -1, -1);
            chk("rand_loads", 32'(loads), 32'd8);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
